seg_scan_display: RTL

Parametrised multiplexed seven-segment scanner; successor to the fixed 8-digit scan/decode path behind the clock's set-time display.
- Drives DIGITS digit selects (chs) and one shared segment bus (oout) from packed hex nibbles.
- Adds per-digit decimal point, blanking, blinking (digit under edit) and 8-level brightness by PWM inside each scan slot.
- Latches input data once per frame so a digit never changes mid-frame.

---
 rtl/seg_scan_display.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/seg_scan_display.sv
// seg_scan_display: multiplexed seven-segment scanner.
//
// Scans DIGITS digits, one SCAN_DIV-cycle slot each, over a shared segment bus.
// Display data is snapshotted once per frame, so a digit never changes mid-frame.
// Brightness is a PWM on-window inside each slot; blinking is frame-count based.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   digit_data    packed hex nibbles, digit k = [4k+3:4k]
//   dp            decimal point per digit
//   blank_mask    1 = digit dark
//   blink_mask    1 = digit blinks while blink_en is set
//   blink_en      global blink enable
//   bright        brightness 0..7, sampled live (not snapshotted)
//   chs           one-hot digit select, polarity per CHS_ACTIVE_LOW
//   oout          {dp, g..a}, polarity per SEG_ACTIVE_LOW
//   frame_tick    one-cycle pulse after each frame boundary
module seg_scan_display #(
    parameter int unsigned DIGITS         = 8,
    parameter int unsigned SCAN_DIV       = 50000,
    parameter int unsigned BLINK_FRAMES   = 64,
    parameter bit          CHS_ACTIVE_LOW = 1'b1,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   digit_data,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blank_mask,
    input  logic [DIGITS-1:0]     blink_mask,
    input  logic                  blink_en,
    input  logic [2:0]            bright,
    output logic [DIGITS-1:0]     chs,
    output logic [7:0]            oout,
    output logic                  frame_tick
);

    localparam int unsigned PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    // Must hold 8*SCAN_DIV even when SCAN_DIV is a power of two.
    localparam int unsigned ON_W  = PRE_W + 4;

    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [FC_W-1:0]   FC_LAST  = FC_W'(BLINK_FRAMES - 1);
    localparam logic [DIGITS-1:0] CHS_OFF  = {DIGITS{CHS_ACTIVE_LOW}};
    localparam logic [7:0]        SEG_OFF  = {8{SEG_ACTIVE_LOW}};

    logic [PRE_W-1:0]    r_pre;
    logic [IDX_W-1:0]    r_idx;
    logic [FC_W-1:0]     r_frame_cnt;
    logic                r_phase;
    logic [4*DIGITS-1:0] r_snap_data;
    logic [DIGITS-1:0]   r_snap_dp;
    logic [DIGITS-1:0]   r_snap_blank;
    logic [DIGITS-1:0]   r_snap_blink;
    logic                r_snap_blink_en;
    logic [DIGITS-1:0]   r_chs;
    logic [7:0]          r_oout;
    logic                r_frame_tick;

    logic                w_pre_last;
    logic                w_frame_end;
    logic [ON_W-1:0]     w_on_len;
    logic                w_in_window;
    logic [3:0]          w_nib;
    logic                w_dp_sel;
    logic                w_blank_sel;
    logic                w_blink_sel;
    logic [DIGITS-1:0]   w_onehot;
    logic [6:0]          w_seg;
    logic                w_lit;
    logic [DIGITS-1:0]   w_chs_next;
    logic [7:0]          w_oout_next;

    assign w_pre_last  = (r_pre == PRE_LAST);
    assign w_frame_end = w_pre_last && (r_idx == IDX_LAST);

    assign w_on_len    = ((ON_W'(bright) + ON_W'(1)) * ON_W'(SCAN_DIV)) >> 3;
    assign w_in_window = (ON_W'(r_pre) < w_on_len);

    // Select the snapshot fields of the digit in the current slot.
    always_comb begin
        w_nib       = 4'h0;
        w_dp_sel    = 1'b0;
        w_blank_sel = 1'b0;
        w_blink_sel = 1'b0;
        w_onehot    = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_nib       = r_snap_data[4*k +: 4];
                w_dp_sel    = r_snap_dp[k];
                w_blank_sel = r_snap_blank[k];
                w_blink_sel = r_snap_blink[k];
                w_onehot[k] = 1'b1;
            end
        end
    end

    // Hex decode, active-high segments g..a.
    always_comb begin
        w_seg = 7'h00;
        case (w_nib)
            4'h0: w_seg = 7'h3F;
            4'h1: w_seg = 7'h06;
            4'h2: w_seg = 7'h5B;
            4'h3: w_seg = 7'h4F;
            4'h4: w_seg = 7'h66;
            4'h5: w_seg = 7'h6D;
            4'h6: w_seg = 7'h7D;
            4'h7: w_seg = 7'h07;
            4'h8: w_seg = 7'h7F;
            4'h9: w_seg = 7'h6F;
            4'hA: w_seg = 7'h77;
            4'hB: w_seg = 7'h7C;
            4'hC: w_seg = 7'h39;
            4'hD: w_seg = 7'h5E;
            4'hE: w_seg = 7'h79;
            default: w_seg = 7'h71;
        endcase
    end

    // Dark slots drive neither select nor segments, so nothing can ghost.
    assign w_lit = !w_blank_sel && !(r_snap_blink_en && w_blink_sel && r_phase) && w_in_window;
    assign w_chs_next  = (w_lit ? w_onehot : '0) ^ CHS_OFF;
    assign w_oout_next = (w_lit ? {w_dp_sel, w_seg} : 8'h00) ^ SEG_OFF;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre           <= '0;
            r_idx           <= '0;
            r_frame_cnt     <= '0;
            r_phase         <= 1'b0;
            r_snap_data     <= '0;
            r_snap_dp       <= '0;
            r_snap_blank    <= '1;
            r_snap_blink    <= '0;
            r_snap_blink_en <= 1'b0;
            r_chs           <= CHS_OFF;
            r_oout          <= SEG_OFF;
            r_frame_tick    <= 1'b0;
        end else begin
            r_pre        <= w_pre_last ? '0 : r_pre + PRE_W'(1);
            r_chs        <= w_chs_next;
            r_oout       <= w_oout_next;
            r_frame_tick <= w_frame_end;
            if (w_pre_last) begin
                r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
            end
            if (w_frame_end) begin
                r_snap_data     <= digit_data;
                r_snap_dp       <= dp;
                r_snap_blank    <= blank_mask;
                r_snap_blink    <= blink_mask;
                r_snap_blink_en <= blink_en;
                if (r_frame_cnt == FC_LAST) begin
                    r_frame_cnt <= '0;
                    r_phase     <= ~r_phase;
                end else begin
                    r_frame_cnt <= r_frame_cnt + FC_W'(1);
                end
            end
        end
    end

    assign chs        = r_chs;
    assign oout       = r_oout;
    assign frame_tick = r_frame_tick;

endmodule
